// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: memory read port, redirect request and the decode-side
// valid/ready instruction handshake.
interface fetch_unit_if #(
  parameter int AW = 30
) ();
  logic          mem_re;
  logic [AW-1:0] memaddr;
  logic [31:0]   mem_rdata;
  logic          mem_ack;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic [31:0]   ir;
  logic [AW-1:0] ir_pc;
  logic          ir_valid;
  logic          ir_ready;

  modport master (
    output mem_re, memaddr, ir, ir_pc, ir_valid,
    input  mem_rdata, mem_ack, redirect, redirect_pc, ir_ready
  );

  modport slave (
    input  mem_re, memaddr, ir, ir_pc, ir_valid,
    output mem_rdata, mem_ack, redirect, redirect_pc, ir_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding sequential word read feeding a show-ahead
// prefetch FIFO; redirect flushes the queue and drains any in-flight read.
module fetch_unit #(
  parameter int DEPTH = 4,
  parameter int AW    = 30
) (
  input  logic         clk_i,
  input  logic         rst_i,
  fetch_unit_if.master fetch_io
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          mem_re_q, mem_re_d;
  logic [AW-1:0] memaddr_q, memaddr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] count_pop;
  logic [31:0]   ir_q, ir_d;
  logic [AW-1:0] ir_pc_q, ir_pc_d;
  logic          ir_valid_q, ir_valid_d;
  logic [31:0]   data_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q [DEPTH];
  logic          ack, push, pop;

  assign ack       = mem_re_q & fetch_io.mem_ack;
  assign pop       = fetch_io.ir_ready & (count_q != '0) & ~fetch_io.redirect;
  assign count_pop = count_q - CW'(pop);

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    mem_re_d   = mem_re_q;
    memaddr_d  = memaddr_q;
    push       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (fetch_io.redirect) begin
          fetch_pc_d = fetch_io.redirect_pc;
        end else if (count_pop < DEPTH_C) begin
          mem_re_d   = 1'b1;
          memaddr_d  = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + AW'(1);
          state_d    = REQ;
        end
      end
      REQ: begin
        if (fetch_io.redirect) begin
          fetch_pc_d = fetch_io.redirect_pc;
          if (ack) begin
            mem_re_d = 1'b0;
            state_d  = IDLE;
          end else begin
            state_d  = DRAIN;
          end
        end else if (ack) begin
          push = 1'b1;
          // The next response must always have a free slot waiting for it.
          if (count_pop + CW'(1) < DEPTH_C) begin
            memaddr_d  = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + AW'(1);
          end else begin
            mem_re_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      DRAIN: begin
        if (fetch_io.redirect) fetch_pc_d = fetch_io.redirect_pc;
        if (ack) begin
          mem_re_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        mem_re_d = 1'b0;
        state_d  = IDLE;
      end
    endcase

    if (fetch_io.redirect) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + PW'(pop);
      wr_ptr_d = wr_ptr_q + PW'(push);
      count_d  = count_q + CW'(push) - CW'(pop);
    end

    // Show-ahead head register; a push into an empty queue bypasses storage.
    ir_d    = data_mem_q[rd_ptr_d];
    ir_pc_d = pc_mem_q[rd_ptr_d];
    if (push && (wr_ptr_q == rd_ptr_d)) begin
      ir_d    = fetch_io.mem_rdata;
      ir_pc_d = memaddr_q;
    end
    if (count_d == '0) begin
      ir_d    = ir_q;
      ir_pc_d = ir_pc_q;
    end
    ir_valid_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      fetch_pc_q <= '0;
      mem_re_q   <= 1'b0;
      memaddr_q  <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_q       <= '0;
      ir_pc_q    <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      mem_re_q   <= mem_re_d;
      memaddr_q  <= memaddr_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && push) begin
      data_mem_q[wr_ptr_q] <= fetch_io.mem_rdata;
      pc_mem_q[wr_ptr_q]   <= memaddr_q;
    end
  end

  assign fetch_io.mem_re   = mem_re_q;
  assign fetch_io.memaddr  = memaddr_q;
  assign fetch_io.ir       = ir_q;
  assign fetch_io.ir_pc    = ir_pc_q;
  assign fetch_io.ir_valid = ir_valid_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed timing scenarios plus randomized waits, stalls
// and redirects against an instruction-stream / occupancy reference model.
module tb_fetch_unit;
  localparam int DEPTH = 4;
  localparam int AW    = 30;

  logic clk;
  logic rst;

  fetch_unit_if #(.AW(AW)) bus ();

  fetch_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .fetch_io (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_assert = 0;
  int            n_fail   = 0;
  int            n_req, n_pop, occ, waits_left, wait_n;
  bit            rand_waits, force_ack, stale;
  logic          prev_re, prev_ack;
  logic [AW-1:0] exp_req, exp_ir, cur_addr;

  function automatic logic [31:0] fdata(input logic [AW-1:0] a);
    return 32'h1000_0000 + {2'b00, a};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model, runs just after each edge: checks issue order and address
  // stability, then answers after the chosen number of wait states.
  task automatic respond();
    if (rst) begin
      bus.mem_ack   = force_ack;
      bus.mem_rdata = '0;
      return;
    end
    if (bus.mem_re) begin
      if (!prev_re || prev_ack) begin
        check("req_addr", 64'(bus.memaddr), 64'(exp_req));
        exp_req    = exp_req + 1'b1;
        cur_addr   = bus.memaddr;
        waits_left = rand_waits ? int'($urandom_range(0, 3)) : wait_n;
        stale      = 1'b0;
        n_req++;
      end else begin
        check("addr_stable", 64'(bus.memaddr), 64'(cur_addr));
      end
      if (waits_left == 0) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = fdata(bus.memaddr);
      end else begin
        bus.mem_ack = 1'b0;
        waits_left--;
      end
    end else begin
      bus.mem_ack = 1'b0;
    end
  endtask

  // One clock: account for what the coming edge does, then check afterwards.
  task automatic step();
    if (rst) begin
      occ   = 0;
      stale = 1'b0;
    end else if (bus.redirect) begin
      if (bus.mem_re) stale = 1'b1;
      occ     = 0;
      exp_req = bus.redirect_pc;
      exp_ir  = bus.redirect_pc;
    end else begin
      if (bus.ir_valid && bus.ir_ready) begin
        check("ir_pc", 64'(bus.ir_pc), 64'(exp_ir));
        check("ir", 64'(bus.ir), 64'(fdata(exp_ir)));
        exp_ir = exp_ir + 1'b1;
        n_pop++;
        occ--;
      end
      if (bus.mem_re && bus.mem_ack && !stale) occ++;
    end
    prev_re  = bus.mem_re;
    prev_ack = bus.mem_ack;
    @(posedge clk);
    #1;
    check("ir_valid", 64'(bus.ir_valid), 64'(occ != 0));
    check("occ_bound", 64'(occ <= DEPTH), 64'd1);
    respond();
  endtask

  task automatic do_reset(input int n);
    rst          = 1'b1;
    bus.redirect = 1'b0;
    repeat (n) step();
    rst         = 1'b0;
    force_ack   = 1'b0;
    bus.mem_ack = 1'b0;
    exp_req     = '0;
    exp_ir      = '0;
    n_req       = 0;
    n_pop       = 0;
  endtask

  initial begin
    rst             = 1'b1;
    force_ack       = 1'b1;
    rand_waits      = 1'b0;
    wait_n          = 0;
    stale           = 1'b0;
    occ             = 0;
    n_req           = 0;
    n_pop           = 0;
    exp_req         = '0;
    exp_ir          = '0;
    cur_addr        = '0;
    waits_left      = 0;
    bus.mem_ack     = 1'b1;
    bus.mem_rdata   = '0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = '0;
    bus.ir_ready    = 1'b1;

    // Reset held with ack asserted
    repeat (3) begin
      step();
      check("rst_mem_re", 64'(bus.mem_re), 64'd0);
      check("rst_memaddr", 64'(bus.memaddr), 64'd0);
    end

    // Release and stream from zero-wait memory
    rst = 1'b0; force_ack = 1'b0; bus.mem_ack = 1'b0;
    step();
    check("first_re", 64'(bus.mem_re), 64'd1);
    check("first_addr", 64'(bus.memaddr), 64'd0);
    repeat (17) begin
      step();
      check("stream_valid", 64'(bus.ir_valid), 64'd1);
    end
    check("stream_pops", 64'(n_pop), 64'd16);
    check("stream_reqs", 64'(n_req), 64'd18);

    // Backpressure fills the queue, single pop admits one more request
    bus.ir_ready = 1'b0;
    do_reset(1);
    repeat (5) step();
    check("bp_re_low", 64'(bus.mem_re), 64'd0);
    check("bp_reqs", 64'(n_req), 64'd4);
    check("bp_head", 64'(bus.ir_pc), 64'd0);
    repeat (3) step();
    check("bp_hold_re", 64'(bus.mem_re), 64'd0);
    bus.ir_ready = 1'b1;
    step();
    bus.ir_ready = 1'b0;
    check("bp_resume_re", 64'(bus.mem_re), 64'd1);
    check("bp_resume_addr", 64'(bus.memaddr), 64'd4);
    check("bp_head_next", 64'(bus.ir_pc), 64'd1);
    step();
    check("bp_full_again", 64'(bus.mem_re), 64'd0);

    // Three wait states per read
    bus.ir_ready = 1'b1;
    wait_n = 3;
    do_reset(2);
    repeat (17) step();
    check("ws_pops", 64'(n_pop), 64'd3);
    check("ws_reqs", 64'(n_req), 64'd5);
    check("ws_head", 64'(bus.ir_pc), 64'd3);

    // Redirect while the read of pc 5 is outstanding
    wait_n = 0;
    do_reset(1);
    repeat (5) step();
    wait_n = 3;
    step();
    check("rd_pending_addr", 64'(bus.memaddr), 64'd5);
    bus.redirect = 1'b1; bus.redirect_pc = 30'h100;
    step();
    bus.redirect = 1'b0;
    check("rd_drain_re", 64'(bus.mem_re), 64'd1);
    check("rd_drain_addr", 64'(bus.memaddr), 64'd5);
    step();
    step();
    wait_n = 0;
    step();
    check("rd_drained", 64'(bus.mem_re), 64'd0);
    step();
    check("rd_new_addr", 64'(bus.memaddr), 64'h100);
    step();
    check("rd_first_out", 64'(bus.ir_pc), 64'h100);

    // Redirect coinciding with an ack and a pop
    bus.redirect = 1'b1; bus.redirect_pc = 30'h200;
    step();
    bus.redirect = 1'b0;
    check("co_re_low", 64'(bus.mem_re), 64'd0);
    step();
    check("co_new_addr", 64'(bus.memaddr), 64'h200);
    step();
    check("co_first_out", 64'(bus.ir_pc), 64'h200);

    // Address wrap from all-ones
    do_reset(1);
    bus.redirect = 1'b1; bus.redirect_pc = 30'h3FFF_FFFF;
    step();
    bus.redirect = 1'b0;
    check("wr_idle", 64'(bus.mem_re), 64'd0);
    step();
    check("wr_top_addr", 64'(bus.memaddr), 64'h3FFF_FFFF);
    wait_n = 3;
    step();
    check("wr_wrapped", 64'(bus.memaddr), 64'd0);
    check("wr_head_pc", 64'(bus.ir_pc), 64'h3FFF_FFFF);
    check("wr_head_ir", 64'(bus.ir), 64'h4FFF_FFFF);

    // Reset while a request is pending
    do_reset(1);
    check("rr_re_low", 64'(bus.mem_re), 64'd0);
    wait_n = 0;
    step();
    check("rr_restart", 64'(bus.memaddr), 64'd0);
    step();
    check("rr_first_out", 64'(bus.ir_pc), 64'd0);

    // Random waits, stalls and redirects
    rand_waits = 1'b1;
    do_reset(1);
    for (int i = 0; i < 800; i++) begin
      bus.ir_ready = ($urandom_range(0, 7) < 5);
      bus.redirect = ($urandom_range(0, 29) == 0);
      bus.redirect_pc = ($urandom_range(0, 3) == 0) ?
                        (30'h3FFF_FFFE + 30'($urandom_range(0, 3))) : 30'($urandom());
      step();
    end
    bus.redirect = 1'b0;
    check("rand_progress", 64'(n_pop > 50), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
